spi_xfer_arbiter: RTL

SPI_XFER_ARBITER -- requirements
Module: spi_xfer_arbiter

---
 rtl/spi_arb_pkg.sv | 17 +
 rtl/spi_rr_arb2.sv | 20 ++
 rtl/spi_xfer_arbiter.sv | 168 ++++++++++++++++
 3 files changed

// File: rtl/spi_arb_pkg.sv
// rtl/spi_arb_pkg.sv - shared FSM states, default timing constants and channel type
package spi_arb_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_WAIT,
    ST_RESP,
    ST_GAP
  } state_t;

  localparam int unsigned DEF_GAP_CYCLES     = 4;
  localparam int unsigned DEF_TIMEOUT_CYCLES = 1024;

  typedef logic chan_t;

endpackage

// File: rtl/spi_rr_arb2.sv
// rtl/spi_rr_arb2.sv - two-way round-robin pick: contested grant goes to the channel not served last
module spi_rr_arb2
  import spi_arb_pkg::*;
(
  input  logic [1:0] i_req,
  input  chan_t      i_last,
  output chan_t      o_winner,
  output logic       o_valid
);

  always_comb begin
    o_valid = |i_req;
    if (i_req == 2'b11) begin
      o_winner = ~i_last;
    end else begin
      o_winner = i_req[1];
    end
  end

endmodule

// File: rtl/spi_xfer_arbiter.sv
// rtl/spi_xfer_arbiter.sv - shares one SPI byte engine between two requesters
// Optional WAIT timeout with err_* reporting when SPI_ARB_TIMEOUT_EN is defined.
module spi_xfer_arbiter
  import spi_arb_pkg::*;
#(
  parameter int unsigned GAP_CYCLES     = DEF_GAP_CYCLES,
  parameter int unsigned TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES
) (
  input  logic        PCLK,
  input  logic        PRESET,
  input  logic        req_0,
  input  logic        req_1,
  input  logic [7:0]  tx_data_0,
  input  logic [7:0]  tx_data_1,
  output logic        ack_0,
  output logic        ack_1,
  output logic [7:0]  rx_data_0,
  output logic [7:0]  rx_data_1,
  output logic        err_0,
  output logic        err_1,
  output logic        spi_start,
  output logic        spi_sel,
  output logic [7:0]  spi_tx,
  input  logic        spi_done,
  input  logic [7:0]  spi_rx,
  output logic        busy,
  output logic [15:0] xfer_cnt
);

  if (GAP_CYCLES < 1 || GAP_CYCLES > 255 || TIMEOUT_CYCLES < 2 || TIMEOUT_CYCLES > 65535) begin : g_param_check
    $error("spi_xfer_arbiter: GAP_CYCLES or TIMEOUT_CYCLES out of range");
  end

  state_t      r_state;
  chan_t       r_last;
  chan_t       r_sel;
  logic [7:0]  r_tx;
  logic        r_start;
  logic        r_ack0;
  logic        r_ack1;
  logic [7:0]  r_rx0;
  logic [7:0]  r_rx1;
  logic [15:0] r_xfer_cnt;
  logic [7:0]  r_gap_cnt;
  logic        r_busy;
  chan_t       w_winner;
  logic        w_valid;

  spi_rr_arb2 u_rr (
    .i_req    ({req_1, req_0}),
    .i_last   (r_last),
    .o_winner (w_winner),
    .o_valid  (w_valid)
  );

`ifdef SPI_ARB_TIMEOUT_EN
  logic [15:0] r_wait_cnt;
  logic        r_err0;
  logic        r_err1;
`endif

  always_ff @(posedge PCLK or posedge PRESET) begin
    if (PRESET) begin
      r_state    <= ST_IDLE;
      r_last     <= 1'b1;
      r_sel      <= 1'b0;
      r_tx       <= 8'h00;
      r_start    <= 1'b0;
      r_ack0     <= 1'b0;
      r_ack1     <= 1'b0;
      r_rx0      <= 8'h00;
      r_rx1      <= 8'h00;
      r_xfer_cnt <= 16'h0000;
      r_gap_cnt  <= 8'h00;
      r_busy     <= 1'b0;
`ifdef SPI_ARB_TIMEOUT_EN
      r_wait_cnt <= 16'h0000;
      r_err0     <= 1'b0;
      r_err1     <= 1'b0;
`endif
    end else begin
      r_start <= 1'b0;
      r_ack0  <= 1'b0;
      r_ack1  <= 1'b0;
`ifdef SPI_ARB_TIMEOUT_EN
      r_err0  <= 1'b0;
      r_err1  <= 1'b0;
`endif
      case (r_state)
        ST_IDLE: begin
          if (w_valid) begin
            r_sel   <= w_winner;
            r_tx    <= w_winner ? tx_data_1 : tx_data_0;
            r_start <= 1'b1;
            r_busy  <= 1'b1;
            r_state <= ST_START;
          end
        end
        ST_START: begin
`ifdef SPI_ARB_TIMEOUT_EN
          r_wait_cnt <= 16'h0000;
`endif
          r_state <= ST_WAIT;
        end
        // Outputs of RESP are set on the way in, so ack follows spi_done by one cycle.
        ST_WAIT: begin
          if (spi_done) begin
            if (r_sel) r_rx1 <= spi_rx;
            else       r_rx0 <= spi_rx;
            r_ack0     <= ~r_sel;
            r_ack1     <= r_sel;
            r_last     <= r_sel;
            r_xfer_cnt <= r_xfer_cnt + 16'd1;
            r_state    <= ST_RESP;
          end
`ifdef SPI_ARB_TIMEOUT_EN
          else if (r_wait_cnt == 16'(TIMEOUT_CYCLES - 1)) begin
            r_ack0     <= ~r_sel;
            r_ack1     <= r_sel;
            r_err0     <= ~r_sel;
            r_err1     <= r_sel;
            r_last     <= r_sel;
            r_xfer_cnt <= r_xfer_cnt + 16'd1;
            r_state    <= ST_RESP;
          end else begin
            r_wait_cnt <= r_wait_cnt + 16'd1;
          end
`endif
        end
        ST_RESP: begin
          r_gap_cnt <= 8'(GAP_CYCLES - 1);
          r_state   <= ST_GAP;
        end
        ST_GAP: begin
          if (r_gap_cnt == 8'h00) begin
            r_busy  <= 1'b0;
            r_state <= ST_IDLE;
          end else begin
            r_gap_cnt <= r_gap_cnt - 8'd1;
          end
        end
        default: begin
          r_busy  <= 1'b0;
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  assign ack_0     = r_ack0;
  assign ack_1     = r_ack1;
  assign rx_data_0 = r_rx0;
  assign rx_data_1 = r_rx1;
  assign spi_start = r_start;
  assign spi_sel   = r_sel;
  assign spi_tx    = r_tx;
  assign busy      = r_busy;
  assign xfer_cnt  = r_xfer_cnt;

`ifdef SPI_ARB_TIMEOUT_EN
  assign err_0 = r_err0;
  assign err_1 = r_err1;
`else
  assign err_0 = 1'b0;
  assign err_1 = 1'b0;
`endif

endmodule
